// File: rtl/race_pkg.sv
// Shared types and helpers for the race-logic temporal datapath.
package race_pkg;

   typedef enum {EDGE_RISING, EDGE_FALLING} edge_mode_e;

   typedef enum {IDLE, RUN} cap_state_e;

   function automatic int val_width(input int g);
      return $clog2(g);
   endfunction

endpackage

// File: rtl/first_edge_detect.sv
// First-edge latch: timestamps the first qualifying transition on y
// within a gamma cycle and holds it until cleared.
module first_edge_detect
   import race_pkg::*;
#(
   parameter edge_mode_e EDGE_MODE = EDGE_RISING,
   parameter int         VAL_WIDTH = 4
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 first_i,
   input  logic                 arm_i,
   input  logic                 clear_i,
   input  logic                 y_i,
   input  logic [VAL_WIDTH-1:0] phase_i,
   output logic                 cap_o,
   output logic [VAL_WIDTH-1:0] time_o
);

   localparam logic FALL = (EDGE_MODE == EDGE_FALLING);

   logic                 y_prev_q;
   logic                 cap_q;
   logic [VAL_WIDTH-1:0] time_q;
   logic                 prev_eff;
   logic                 hit;

   // Forcing prev at phase 0 makes a level already active count as time 0.
   assign prev_eff = first_i ? FALL : y_prev_q;
   assign hit      = FALL ? (prev_eff && !y_i) : (!prev_eff && y_i);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         y_prev_q <= 1'b0;
         cap_q    <= 1'b0;
         time_q   <= '0;
      end else begin
         y_prev_q <= y_i;
         if (clear_i) begin
            cap_q  <= 1'b0;
            time_q <= '0;
         end else if (arm_i && !cap_q && hit) begin
            cap_q  <= 1'b1;
            time_q <= phase_i;
         end
      end
   end

   assign cap_o  = cap_q;
   assign time_o = time_q;

endmodule

// File: rtl/t_to_b_capture.sv
// Temporal-to-binary capture stage: gamma phase counter, first-edge
// timestamp and a one-entry valid/ready result register.
module t_to_b_capture
   import race_pkg::*;
#(
   parameter int         GAMMA_CYCLE_WIDTH = 16,
   parameter int         VAL_WIDTH         = val_width(GAMMA_CYCLE_WIDTH),
   parameter edge_mode_e EDGE_MODE         = EDGE_RISING
) (
   input  logic                 clk,
   input  logic                 grst_n,
   input  logic                 en,
   input  logic                 y_in,
   output logic                 grst_out,
   output logic                 out_valid,
   input  logic                 out_ready,
   output logic [VAL_WIDTH-1:0] out_time,
   output logic                 out_inf,
   output logic                 overrun
);

   localparam logic [VAL_WIDTH-1:0] LAST =
      VAL_WIDTH'(GAMMA_CYCLE_WIDTH - 1);

   cap_state_e           state_q, state_d;
   logic [VAL_WIDTH-1:0] phase_q, phase_d;
   logic                 valid_q, valid_d;
   logic [VAL_WIDTH-1:0] time_q, time_d;
   logic                 inf_q, inf_d;
   logic                 ovr_q, ovr_d;

   logic                 run;
   logic                 last;
   logic                 cap;
   logic [VAL_WIDTH-1:0] cap_time;

   assign run  = (state_q == RUN);
   assign last = run && (phase_q == LAST);

   first_edge_detect #(
      .EDGE_MODE (EDGE_MODE),
      .VAL_WIDTH (VAL_WIDTH)
   ) u_fed (
      .clk     (clk),
      .rst_n   (grst_n),
      .first_i (phase_q == '0),
      .arm_i   (run && !last),
      .clear_i (last),
      .y_i     (y_in),
      .phase_i (phase_q),
      .cap_o   (cap),
      .time_o  (cap_time)
   );

   always_comb begin
      state_d = state_q;
      phase_d = phase_q;
      unique case (state_q)
         IDLE: begin
            phase_d = '0;
            if (en) state_d = RUN;
         end
         RUN: begin
            phase_d = phase_q + 1'b1;
            if (last && !en) state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
            phase_d = '0;
         end
      endcase
   end

   // A commit into a stalled holder drops the new result, not the old.
   always_comb begin
      valid_d = valid_q;
      time_d  = time_q;
      inf_d   = inf_q;
      ovr_d   = ovr_q;
      if (last) begin
         if (!valid_q || out_ready) begin
            valid_d = 1'b1;
            time_d  = cap_time;
            inf_d   = !cap;
         end else begin
            ovr_d = 1'b1;
         end
      end else if (valid_q && out_ready) begin
         valid_d = 1'b0;
      end
   end

   always_ff @(posedge clk or negedge grst_n) begin
      if (!grst_n) begin
         state_q <= IDLE;
         phase_q <= '0;
         valid_q <= 1'b0;
         time_q  <= '0;
         inf_q   <= 1'b0;
         ovr_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         phase_q <= phase_d;
         valid_q <= valid_d;
         time_q  <= time_d;
         inf_q   <= inf_d;
         ovr_q   <= ovr_d;
      end
   end

   assign grst_out  = !run || (phase_q == LAST);
   assign out_valid = valid_q;
   assign out_time  = time_q;
   assign out_inf   = inf_q;
   assign overrun   = ovr_q;

endmodule

// File: tb/tb_t_to_b_capture.sv
// Directed bench for t_to_b_capture (G=16), rising and falling instances.
module tb_t_to_b_capture;
   import race_pkg::*;

   logic       clk = 1'b0;
   logic       grst_n;
   logic       en;
   logic       y_in;
   logic       out_ready;

   logic       r_grst, r_valid, r_inf, r_ovr;
   logic [3:0] r_time;
   logic       f_grst, f_valid, f_inf, f_ovr;
   logic [3:0] f_time;

   int nvec = 0;
   int nerr = 0;

   always #5 clk = ~clk;

   t_to_b_capture #(
      .GAMMA_CYCLE_WIDTH (16),
      .EDGE_MODE         (EDGE_RISING)
   ) dut_r (
      .clk       (clk),
      .grst_n    (grst_n),
      .en        (en),
      .y_in      (y_in),
      .grst_out  (r_grst),
      .out_valid (r_valid),
      .out_ready (out_ready),
      .out_time  (r_time),
      .out_inf   (r_inf),
      .overrun   (r_ovr)
   );

   t_to_b_capture #(
      .GAMMA_CYCLE_WIDTH (16),
      .EDGE_MODE         (EDGE_FALLING)
   ) dut_f (
      .clk       (clk),
      .grst_n    (grst_n),
      .en        (en),
      .y_in      (y_in),
      .grst_out  (f_grst),
      .out_valid (f_valid),
      .out_ready (out_ready),
      .out_time  (f_time),
      .out_inf   (f_inf),
      .overrun   (f_ovr)
   );

   // Drives one gamma cycle from phase 0; pat[p] is y_in during phase p.
   task automatic gamma(input logic [15:0] pat, input logic rdy,
                        input int drop_at);
      logic exp_g;
      for (int p = 0; p < 16; p++) begin
         y_in = pat[p];
         if (p == 1) out_ready = rdy;
         if (p == drop_at) en = 1'b0;
         if (p == 0 || p == 15) begin
            exp_g = (p == 15);
            nvec++;
            if (r_grst !== exp_g) begin
               nerr++;
               $display("FAIL grst_phase%0d got=%b exp=%b", p, r_grst, exp_g);
            end
         end
         @(posedge clk); #1;
      end
   endtask

   task automatic test_reset();
      grst_n = 1'b0; en = 1'b0; y_in = 1'b0; out_ready = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      nvec++;
      if ({r_grst, r_valid, r_time, r_inf, r_ovr} !== 8'b1000_0000) begin
         nerr++;
         $display("FAIL reset_r got=%b exp=10000000",
                  {r_grst, r_valid, r_time, r_inf, r_ovr});
      end
      nvec++;
      if ({f_grst, f_valid, f_time, f_inf, f_ovr} !== 8'b1000_0000) begin
         nerr++;
         $display("FAIL reset_f got=%b exp=10000000",
                  {f_grst, f_valid, f_time, f_inf, f_ovr});
      end
      grst_n = 1'b1;
      en = 1'b1;
      out_ready = 1'b1;
      @(posedge clk); #1;
   endtask

   task automatic test_basic();
      gamma(16'hFFE0, 1'b1, -1);
      nvec++;
      if ({r_valid, r_time, r_inf} !== {1'b1, 4'd5, 1'b0}) begin
         nerr++;
         $display("FAIL basic got v=%b t=%0d i=%b exp v=1 t=5 i=0",
                  r_valid, r_time, r_inf);
      end
   endtask

   task automatic test_no_edge();
      gamma(16'h0000, 1'b1, -1);
      nvec++;
      if ({r_valid, r_time, r_inf} !== {1'b1, 4'd0, 1'b1}) begin
         nerr++;
         $display("FAIL no_edge got v=%b t=%0d i=%b exp v=1 t=0 i=1",
                  r_valid, r_time, r_inf);
      end
   endtask

   task automatic test_multi();
      gamma(16'hFE08, 1'b1, -1);
      nvec++;
      if ({r_valid, r_time, r_inf} !== {1'b1, 4'd3, 1'b0}) begin
         nerr++;
         $display("FAIL multi got v=%b t=%0d i=%b exp v=1 t=3 i=0",
                  r_valid, r_time, r_inf);
      end
   endtask

   task automatic test_phase_bounds();
      gamma(16'hFFFF, 1'b1, -1);
      nvec++;
      if ({r_valid, r_time, r_inf} !== {1'b1, 4'd0, 1'b0}) begin
         nerr++;
         $display("FAIL phase0 got v=%b t=%0d i=%b exp v=1 t=0 i=0",
                  r_valid, r_time, r_inf);
      end
      gamma(16'h8000, 1'b1, -1);
      nvec++;
      if ({r_valid, r_time, r_inf} !== {1'b1, 4'd0, 1'b1}) begin
         nerr++;
         $display("FAIL phase15 got v=%b t=%0d i=%b exp v=1 t=0 i=1",
                  r_valid, r_time, r_inf);
      end
   endtask

   task automatic test_back_to_back();
      gamma(16'hFFFC, 1'b0, -1);
      nvec++;
      if ({r_valid, r_time, r_ovr} !== {1'b1, 4'd2, 1'b0}) begin
         nerr++;
         $display("FAIL bp_first got v=%b t=%0d o=%b exp v=1 t=2 o=0",
                  r_valid, r_time, r_ovr);
      end
      gamma(16'hFF80, 1'b0, -1);
      nvec++;
      if ({r_valid, r_time, r_inf, r_ovr} !== {1'b1, 4'd2, 1'b0, 1'b1}) begin
         nerr++;
         $display("FAIL bp_hold got v=%b t=%0d i=%b o=%b exp v=1 t=2 i=0 o=1",
                  r_valid, r_time, r_inf, r_ovr);
      end
      out_ready = 1'b1;
      y_in = 1'b0;
      @(posedge clk); #1;
      nvec++;
      if (r_valid !== 1'b0) begin
         nerr++;
         $display("FAIL bp_xfer got v=%b exp v=0", r_valid);
      end
      for (int p = 1; p < 15; p++) begin
         @(posedge clk); #1;
      end
      nvec++;
      if (r_valid !== 1'b0) begin
         nerr++;
         $display("FAIL bp_empty got v=%b exp v=0", r_valid);
      end
      @(posedge clk); #1;
      nvec++;
      if ({r_valid, r_inf, r_ovr} !== 3'b111) begin
         nerr++;
         $display("FAIL bp_next got v=%b i=%b o=%b exp v=1 i=1 o=1",
                  r_valid, r_inf, r_ovr);
      end
   endtask

   task automatic test_en_stop_reset();
      gamma(16'hFFF0, 1'b0, 6);
      nvec++;
      if ({r_grst, r_valid, r_time, r_inf} !== {1'b1, 1'b1, 4'd4, 1'b0}) begin
         nerr++;
         $display("FAIL en_stop got g=%b v=%b t=%0d i=%b exp g=1 v=1 t=4 i=0",
                  r_grst, r_valid, r_time, r_inf);
      end
      repeat (2) @(posedge clk);
      #1;
      nvec++;
      if ({r_grst, r_valid, r_time} !== {1'b1, 1'b1, 4'd4}) begin
         nerr++;
         $display("FAIL idle_hold got g=%b v=%b t=%0d exp g=1 v=1 t=4",
                  r_grst, r_valid, r_time);
      end
      en = 1'b1;
      y_in = 1'b0;
      @(posedge clk); #1;
      nvec++;
      if (r_grst !== 1'b0) begin
         nerr++;
         $display("FAIL restart got g=%b exp g=0", r_grst);
      end
      repeat (10) @(posedge clk);
      #1;
      grst_n = 1'b0;
      #1;
      nvec++;
      if ({r_grst, r_valid, r_time, r_inf, r_ovr} !== 8'b1000_0000) begin
         nerr++;
         $display("FAIL mid_reset got=%b exp=10000000",
                  {r_grst, r_valid, r_time, r_inf, r_ovr});
      end
   endtask

   task automatic test_falling();
      en = 1'b0;
      out_ready = 1'b1;
      @(posedge clk); #1;
      grst_n = 1'b1;
      en = 1'b1;
      @(posedge clk); #1;
      gamma(16'h00FF, 1'b1, -1);
      nvec++;
      if ({f_valid, f_time, f_inf} !== {1'b1, 4'd8, 1'b0}) begin
         nerr++;
         $display("FAIL falling got v=%b t=%0d i=%b exp v=1 t=8 i=0",
                  f_valid, f_time, f_inf);
      end
   endtask

   initial begin
      #200000;
      $display("FAIL timeout");
      $fatal(1, "timeout");
   end

   initial begin
      test_reset();
      test_basic();
      test_no_edge();
      test_multi();
      test_phase_bounds();
      test_back_to_back();
      test_en_stop_reset();
      test_falling();
      $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
      $finish;
   end

endmodule
